otter_rf_multiport: RTL and testbench
=====================================

Name: otter_rf_multiport

Overview:
- Parametrised register file for the 5-stage OTTER pipeline, replacing the fixed 32x32, 2-read, 1-write file.
- Adds a configurable number of combinational read ports and optional write-first bypass, so the WB-stage write is visible to ID in the same cycle.
- Adds a pending-write scoreboard for hazard detection and a post-reset hardware clear sequence.
- Sits between ID (reads, issue) and WB (write).

Parameters:
XLEN, 32, data width in bits
DEPTH, 32, number of registers (power of 2, >= 2)
NUM_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = read of the register being written this cycle returns RF_WD
ZERO_REG, 1, 1 = register 0 is hardwired to zero, never written, never busy
AW, $clog2(DEPTH), address width (derived, localparam)

Ports:
CLK  in  1  clock, all state updates on the rising edge
RST_N  in  1  synchronous, active-low reset
RF_RADDR  in  NUM_RD*AW  read addresses, port i at bits [i*AW +: AW]
RF_RDATA  out  NUM_RD*XLEN  read data, combinational from RF_RADDR
RF_BUSY  out  NUM_RD  1 = register on port i has an outstanding write
RF_WA  in  AW  write address
RF_WD  in  XLEN  write data
RF_EN  in  1  write enable (WB stage)
RF_ISSUE_EN  in  1  instruction with destination issued from ID
RF_ISSUE_RD  in  AW  destination of the issued instruction
RF_READY  out  1  1 = clear sequence finished, file usable

Behaviour:
- Reset: RST_N low at a rising edge sets state to CLEAR, clear counter to 0 and all scoreboard bits to 0.
  - While in CLEAR, all RF_RDATA outputs are 0, all RF_BUSY bits are 0 and RF_READY is 0.
- CLEAR state:
  - Each cycle with RST_N high writes 0 to ram[cnt], then increments cnt.
  - When cnt == DEPTH-1 has been written, the state moves to RUN. RF_READY rises exactly DEPTH cycles after the first edge with RST_N high.
  - RF_EN and RF_ISSUE_EN are ignored in CLEAR.
- RUN state:
  - Write: on a rising edge with RF_EN=1, ram[RF_WA] <= RF_WD. If ZERO_REG=1 and RF_WA==0, the write is suppressed.
  - Read port i, combinational:
    - If ZERO_REG=1 and the address is 0, data is 0.
    - Otherwise, if BYPASS=1, RF_EN=1 and RF_WA equals the read address, data is RF_WD.
    - Otherwise, data is ram[addr].
  - Multiple ports reading the same address each return the same value.
- Scoreboard, one bit per register:
  - ISSUE_EN sets sb[ISSUE_RD].
  - RF_EN clears sb[RF_WA].
  - If both target the same register in the same cycle, set wins (a newer writer is in flight).
  - With ZERO_REG=1, sb[0] is never set.
- RF_BUSY[i] = sb[addr_i], forced to 0 in either case:
  - BYPASS=1 and the same-cycle write address matches addr_i;
  - ZERO_REG=1 and addr_i == 0.
- Reset mid-CLEAR or mid-RUN: the file returns to CLEAR, cnt restarts at 0 and the full clear is repeated. Register contents are not guaranteed until RF_READY.
- No X output: every path to RF_RDATA is defined in all states.

Decomposition:
- Package otter_rf_pkg holds:
  - rf_state_t enum {CLEAR, RUN};
  - default XLEN/DEPTH constants;
  - the helper function used for port slicing.
- One sub-module, rf_scoreboard (DEPTH, AW): holds the set/clear/priority logic and the BUSY lookup per port.
- Storage, clear FSM and read muxing stay in otter_rf_multiport.

Test Plan:
- Clear: pulse RST_N low 2 cycles with DEPTH=32, then release. Required: RF_READY=0 for exactly 32 cycles, then 1. Reads of x1..x31 return 0, and writes attempted during CLEAR are not retained.
- Write/read: RF_EN=1, WA=5, WD=0xDEADBEEF. Next cycle RADDR0=5 must give 0xDEADBEEF. WA=0, WD=0x1234 must leave x0 reading 0.
- Bypass: in the same cycle, RF_EN=1, WA=7, WD=0xA5A5A5A5 and RADDR1=7. RDATA1 must equal 0xA5A5A5A5 combinationally. With BYPASS=0 it must return the old value.
- Scoreboard: ISSUE_EN with RD=9 gives RF_BUSY=1 next cycle for any port reading x9. A write to x9 clears it. Issue and write of x9 in the same cycle must leave BUSY=1.
- NUM_RD=4: ports read 0, 3, 3, 31 after writes x3=0x11, x31=0x22. Required: 0, 0x11, 0x11, 0x22.
- Mid-run reset: after x3=0x11, assert RST_N for 1 cycle. Required: RF_READY drops, BUSY bits are 0, and after 32 cycles x3 reads 0.

Source files
------------

// File: rtl/otter_rf_pkg.sv
// Shared types, default sizes and port-slicing helper for the OTTER register file.
package otter_rf_pkg;

   typedef enum logic {CLEAR, RUN} rf_state_t;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned DEPTH_DEF = 32;

   // LSB of port `port` in a bus of equally sized fields of `width` bits.
   function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
      return port * width;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, with per-port busy lookup.
module rf_scoreboard
   import otter_rf_pkg::*;
#(
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned AW       = $clog2(DEPTH),
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               issue_en_i,
   input  logic [AW-1:0]      issue_rd_i,
   input  logic               wr_en_i,
   input  logic [AW-1:0]      wa_i,
   input  logic [NUM_RD*AW-1:0] raddr_i,
   output logic [NUM_RD-1:0]  busy_o
);

   logic [DEPTH-1:0] sb_q, sb_d;
   logic [AW-1:0]    lk_addr;

   // Clear first so that a same-cycle issue to the same register wins.
   always_comb begin
      sb_d = sb_q;
      if (wr_en_i) sb_d[wa_i] = 1'b0;
      if (issue_en_i) sb_d[issue_rd_i] = 1'b1;
      if (ZERO_REG != 0) sb_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) sb_q <= '0;
      else         sb_q <= sb_d;
   end

   always_comb begin
      busy_o  = '0;
      lk_addr = '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         lk_addr   = raddr_i[port_lsb(i, AW) +: AW];
         busy_o[i] = sb_q[lk_addr];
         if ((BYPASS != 0) && wr_en_i && (wa_i == lk_addr)) busy_o[i] = 1'b0;
         if ((ZERO_REG != 0) && (lk_addr == '0)) busy_o[i] = 1'b0;
      end
   end

endmodule

// File: rtl/otter_rf_multiport.sv
// Multi-read-port OTTER register file with write-first bypass, pending-write
// scoreboard and a post-reset sequence that zeroes every register.
module otter_rf_multiport
   import otter_rf_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1,
   localparam int unsigned AW      = $clog2(DEPTH)
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic [NUM_RD*AW-1:0]   RF_RADDR,
   output logic [NUM_RD*XLEN-1:0] RF_RDATA,
   output logic [NUM_RD-1:0]      RF_BUSY,
   input  logic [AW-1:0]          RF_WA,
   input  logic [XLEN-1:0]        RF_WD,
   input  logic                   RF_EN,
   input  logic                   RF_ISSUE_EN,
   input  logic [AW-1:0]          RF_ISSUE_RD,
   output logic                   RF_READY
);

   rf_state_t        state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [XLEN-1:0]  ram_q [DEPTH];

   logic             run;
   logic             wr_en;
   logic             ram_we;
   logic [AW-1:0]    ram_wa;
   logic [XLEN-1:0]  ram_wd;
   logic [AW-1:0]    rd_addr;
   logic [XLEN-1:0]  rd_data;
   logic [NUM_RD-1:0] sb_busy;

   assign run      = (state_q == RUN);
   assign wr_en    = run && RF_EN;
   assign RF_READY = run;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(DEPTH - 1)) state_d = RUN;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Single write port shared by the clear sweep and the WB write.
   always_comb begin
      ram_we = 1'b0;
      ram_wa = RF_WA;
      ram_wd = RF_WD;
      if (!run) begin
         ram_we = RST_N;
         ram_wa = cnt_q;
         ram_wd = '0;
      end else if (RF_EN && !((ZERO_REG != 0) && (RF_WA == '0))) begin
         ram_we = RST_N;
      end
   end

   always_ff @(posedge CLK) begin
      if (ram_we) ram_q[ram_wa] <= ram_wd;
   end

   always_comb begin
      RF_RDATA = '0;
      rd_addr  = '0;
      rd_data  = '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         rd_addr = RF_RADDR[port_lsb(i, AW) +: AW];
         rd_data = ram_q[rd_addr];
         if ((BYPASS != 0) && wr_en && (RF_WA == rd_addr)) rd_data = RF_WD;
         if (((ZERO_REG != 0) && (rd_addr == '0)) || !run) rd_data = '0;
         RF_RDATA[port_lsb(i, XLEN) +: XLEN] = rd_data;
      end
   end

   rf_scoreboard #(
      .DEPTH    (DEPTH),
      .AW       (AW),
      .NUM_RD   (NUM_RD),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk_i      (CLK),
      .rst_ni     (RST_N),
      .issue_en_i (run && RF_ISSUE_EN),
      .issue_rd_i (RF_ISSUE_RD),
      .wr_en_i    (wr_en),
      .wa_i       (RF_WA),
      .raddr_i    (RF_RADDR),
      .busy_o     (sb_busy)
   );

   assign RF_BUSY = run ? sb_busy : '0;

endmodule

// File: tb/tb_otter_rf_multiport.sv
// Directed bench: a 4-port bypassing file and a 2-port non-bypassing file
// share clock, reset and write/issue inputs.
module tb_otter_rf_multiport;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [19:0] raddr;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic        en;
   logic        issue_en;
   logic [4:0]  issue_rd;

   logic [127:0] rdata4;
   logic [3:0]   busy4;
   logic         ready4;
   logic [63:0]  rdata2;
   logic [1:0]   busy2;
   logic         ready2;

   int n_tests = 0;
   int n_fail  = 0;
   int cycles;

   always #5 clk = ~clk;

   otter_rf_multiport #(
      .NUM_RD (4),
      .BYPASS (1)
   ) dut (
      .CLK         (clk),
      .RST_N       (rst_n),
      .RF_RADDR    (raddr),
      .RF_RDATA    (rdata4),
      .RF_BUSY     (busy4),
      .RF_WA       (wa),
      .RF_WD       (wd),
      .RF_EN       (en),
      .RF_ISSUE_EN (issue_en),
      .RF_ISSUE_RD (issue_rd),
      .RF_READY    (ready4)
   );

   otter_rf_multiport #(
      .NUM_RD (2),
      .BYPASS (0)
   ) dut_nb (
      .CLK         (clk),
      .RST_N       (rst_n),
      .RF_RADDR    (raddr[9:0]),
      .RF_RDATA    (rdata2),
      .RF_BUSY     (busy2),
      .RF_WA       (wa),
      .RF_WD       (wd),
      .RF_EN       (en),
      .RF_ISSUE_EN (issue_en),
      .RF_ISSUE_RD (issue_rd),
      .RF_READY    (ready2)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int port, input logic [4:0] a);
      raddr[port*5 +: 5] = a;
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
      en = 1'b1;
      wa = a;
      wd = d;
      tick();
      en = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      raddr    = '0;
      wa       = '0;
      wd       = '0;
      en       = 1'b0;
      issue_en = 1'b0;
      issue_rd = '0;
      tick();
      tick();

      // Release reset while hammering writes/issues that CLEAR must ignore.
      rst_n    = 1'b1;
      en       = 1'b1;
      wa       = 5'd3;
      wd       = 32'hFFFF_FFFF;
      issue_en = 1'b1;
      issue_rd = 5'd4;
      set_rd(0, 5'd3);
      set_rd(1, 5'd4);
      #1;
      check_eq("clear_ready_pre", {30'd0, ready4, ready2}, 32'd0);
      check_eq("clear_rdata_zero", rdata4[31:0], 32'd0);
      check_eq("clear_busy_zero", {26'd0, busy4, busy2}, 32'd0);
      for (int k = 1; k <= 32; k++) begin
         tick();
         if (k == 32) en = 1'b0;
         if (k == 32) issue_en = 1'b0;
         check_eq($sformatf("ready_after_edge%0d", k), {31'd0, ready4},
                  (k == 32) ? 32'd1 : 32'd0);
      end
      check_eq("ready_nb", {31'd0, ready2}, 32'd1);
      check_eq("busy_x4_ignored", {31'd0, busy4[1]}, 32'd0);
      for (int r = 1; r < 32; r++) begin
         set_rd(0, 5'(r));
         #1;
         check_eq($sformatf("cleared_x%0d", r), rdata4[31:0], 32'd0);
      end

      // Write then read; x0 write suppressed.
      write_reg(5'd5, 32'hDEAD_BEEF);
      set_rd(0, 5'd5);
      #1;
      check_eq("read_x5", rdata4[31:0], 32'hDEAD_BEEF);
      en = 1'b1; wa = 5'd0; wd = 32'h1234;
      set_rd(0, 5'd0);
      #1;
      check_eq("x0_same_cycle", rdata4[31:0], 32'd0);
      tick();
      en = 1'b0;
      #1;
      check_eq("x0_after_write", rdata4[31:0], 32'd0);

      // Bypass versus no bypass.
      write_reg(5'd7, 32'h1111_1111);
      en = 1'b1; wa = 5'd7; wd = 32'hA5A5_A5A5;
      set_rd(1, 5'd7);
      #1;
      check_eq("bypass_rd1", rdata4[63:32], 32'hA5A5_A5A5);
      check_eq("nobypass_rd1_old", rdata2[63:32], 32'h1111_1111);
      tick();
      en = 1'b0;
      #1;
      check_eq("nobypass_rd1_new", rdata2[63:32], 32'hA5A5_A5A5);

      // Scoreboard.
      for (int p = 0; p < 4; p++) set_rd(p, 5'd9);
      issue_en = 1'b1; issue_rd = 5'd9;
      #1;
      check_eq("busy_before_issue_edge", {28'd0, busy4}, 32'd0);
      tick();
      issue_en = 1'b0;
      #1;
      check_eq("busy4_x9", {28'd0, busy4}, 32'hF);
      check_eq("busy2_x9", {30'd0, busy2}, 32'h3);
      en = 1'b1; wa = 5'd9; wd = 32'h99;
      #1;
      check_eq("busy4_bypass_mask", {28'd0, busy4}, 32'd0);
      check_eq("busy2_no_mask", {30'd0, busy2}, 32'h3);
      tick();
      en = 1'b0;
      #1;
      check_eq("busy_cleared", {26'd0, busy4, busy2}, 32'd0);
      en = 1'b1; issue_en = 1'b1; wd = 32'h9A;
      tick();
      en = 1'b0; issue_en = 1'b0;
      #1;
      check_eq("busy_set_wins", {26'd0, busy4, busy2}, 32'h3F);
      issue_en = 1'b1; issue_rd = 5'd0;
      set_rd(0, 5'd0);
      tick();
      issue_en = 1'b0;
      #1;
      check_eq("busy_x0_never", {31'd0, busy4[0]}, 32'd0);

      // Four ports.
      write_reg(5'd3, 32'h11);
      write_reg(5'd31, 32'h22);
      set_rd(0, 5'd0); set_rd(1, 5'd3); set_rd(2, 5'd3); set_rd(3, 5'd31);
      #1;
      check_eq("p0_x0", rdata4[31:0], 32'd0);
      check_eq("p1_x3", rdata4[63:32], 32'h11);
      check_eq("p2_x3", rdata4[95:64], 32'h11);
      check_eq("p3_x31", rdata4[127:96], 32'h22);

      // Mid-run reset with an outstanding issue.
      issue_en = 1'b1; issue_rd = 5'd3;
      tick();
      issue_en = 1'b0;
      #1;
      check_eq("busy_x3_pre_reset", {31'd0, busy4[1]}, 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      check_eq("midrst_ready", {30'd0, ready4, ready2}, 32'd0);
      check_eq("midrst_busy", {26'd0, busy4, busy2}, 32'd0);
      check_eq("midrst_rdata", rdata4[63:32], 32'd0);
      cycles = 0;
      while (!ready4 && cycles < 40) begin
         tick();
         cycles++;
      end
      check_eq("midrst_clear_cycles", 32'(cycles), 32'd32);
      check_eq("midrst_x3_zero", rdata4[63:32], 32'd0);
      check_eq("midrst_x31_zero", rdata4[127:96], 32'd0);
      check_eq("midrst_busy_after", {28'd0, busy4}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
